// File: rtl/data_mem_responder_pkg.sv
// Shared constants and types for the data-cache block memory responder.
// Holds the block/address geometry, the responder FSM encoding and the
// saturating-counter helper used by the completion counters.
package data_mem_responder_pkg;

    localparam int BLK_BITS     = 256;  // one cache block
    localparam int ADDR_BITS    = 32;
    localparam int OFFSET_BITS  = 5;    // byte offset inside a 32-byte block
    localparam int CNT_BITS     = 16;   // completion counter width
    localparam int LAT_CNT_BITS = 4;    // holds LATENCY-1 for LATENCY up to 15

    localparam logic [CNT_BITS-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_e;

    function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Data-cache <-> block memory bundle.
// master: data cache side (drives address, requests, write data).
// slave : memory responder side (drives read data, completion pulses, busy, counters).
interface data_mem_responder_if;
    import data_mem_responder_pkg::*;

    logic [ADDR_BITS-1:0] address_fDC;
    logic                 dBlkRead;
    logic                 dBlkWrite;
    logic [BLK_BITS-1:0]  block_write_fDC;
    logic [BLK_BITS-1:0]  block_read_2DC;
    logic                 block_read_2DC_valid;
    logic                 block_write_2DC_valid;
    logic                 busy;
    logic [CNT_BITS-1:0]  read_count;
    logic [CNT_BITS-1:0]  write_count;

    modport master (
        output address_fDC, dBlkRead, dBlkWrite, block_write_fDC,
        input  block_read_2DC, block_read_2DC_valid, block_write_2DC_valid,
               busy, read_count, write_count
    );

    modport slave (
        input  address_fDC, dBlkRead, dBlkWrite, block_write_fDC,
        output block_read_2DC, block_read_2DC_valid, block_write_2DC_valid,
               busy, read_count, write_count
    );

endinterface

// File: rtl/data_mem_responder_block_ram.sv
// Block array: 2**IDX_BITS blocks, one synchronous write port, one synchronous read port.
// Latency: write lands and read data registers on the edge the enable is sampled.
// Backpressure: none; the array contents are never reset, only the read register is.
// Ports: clk_i/rst_i, we_i/wr_idx_i/wr_dat_i (write), re_i/rd_idx_i/rd_dat_o (read).
module block_ram #(
    parameter int IDX_BITS = 6,
    parameter int DAT_BITS = 256
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                we_i,
    input  logic [IDX_BITS-1:0] wr_idx_i,
    input  logic [DAT_BITS-1:0] wr_dat_i,
    input  logic                re_i,
    input  logic [IDX_BITS-1:0] rd_idx_i,
    output logic [DAT_BITS-1:0] rd_dat_o
);

    localparam int DEPTH = 1 << IDX_BITS;

    logic [DAT_BITS-1:0] mem_q [DEPTH];
    logic [DAT_BITS-1:0] rd_dat_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[wr_idx_i] <= wr_dat_i;
        end
    end

    // Read register only changes on a read, so it holds the last block returned.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_dat_q <= '0;
        end else if (re_i) begin
            rd_dat_q <= mem_q[rd_idx_i];
        end
    end

    assign rd_dat_o = rd_dat_q;

endmodule

// File: rtl/data_mem_responder.sv
// Fixed-latency block memory responder for the data cache (IDLE -> WAIT -> RESP).
// Latency: request accepted at edge k gives a one-cycle valid after edge k+LATENCY.
// Backpressure: requests are levels held until accepted; accepts only from IDLE.
// Ports: CLK, RESET (async, active-high), bus (slave modport: address, read/write
// requests, write data, read data, completion pulses, busy, completion counters).
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int LATENCY  = 4,
    parameter int IDX_BITS = 6
) (
    input  logic                 CLK,
    input  logic                 RESET,
    data_mem_responder_if.slave  bus
);

    localparam logic [LAT_CNT_BITS-1:0] LAT_INIT = LAT_CNT_BITS'(LATENCY - 1);

    state_e                               state_q, state_d;
    op_e                                  op_q, op_d;
    logic [LAT_CNT_BITS-1:0]              lat_q, lat_d;
    logic [ADDR_BITS-1:OFFSET_BITS]       addr_q, addr_d;
    logic [BLK_BITS-1:0]                  wdat_q, wdat_d;
    logic [CNT_BITS-1:0]                  read_count_q, read_count_d;
    logic [CNT_BITS-1:0]                  write_count_q, write_count_d;

    logic                                 req_hold;
    logic                                 ram_we;
    logic                                 ram_re;
    logic [IDX_BITS-1:0]                  ram_idx;
    logic                                 unused_offset;

    // Byte offset inside a block never matters.
    assign unused_offset = ^bus.address_fDC[OFFSET_BITS-1:0];

    // Upper address bits are kept for the abort compare but not for indexing,
    // so the array aliases by wrap-around.
    assign ram_idx = addr_q[IDX_BITS+OFFSET_BITS-1:OFFSET_BITS];

    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        lat_d         = lat_q;
        addr_d        = addr_q;
        wdat_d        = wdat_q;
        read_count_d  = read_count_q;
        write_count_d = write_count_q;
        req_hold      = 1'b0;
        ram_we        = 1'b0;
        ram_re        = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // Write wins a tie; a held read is picked up on a later IDLE cycle.
                if (bus.dBlkWrite || bus.dBlkRead) begin
                    op_d    = bus.dBlkWrite ? OP_WRITE : OP_READ;
                    addr_d  = bus.address_fDC[ADDR_BITS-1:OFFSET_BITS];
                    wdat_d  = bus.block_write_fDC;
                    lat_d   = LAT_INIT;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                req_hold = (op_q == OP_WRITE) ? bus.dBlkWrite : bus.dBlkRead;
                // Abort takes priority over completion, even on the final WAIT edge.
                if (!req_hold || (bus.address_fDC[ADDR_BITS-1:OFFSET_BITS] != addr_q)) begin
                    state_d = ST_IDLE;
                end else if (lat_q == '0) begin
                    state_d = ST_RESP;
                    if (op_q == OP_WRITE) begin
                        ram_we        = 1'b1;
                        write_count_d = sat_inc(write_count_q);
                    end else begin
                        ram_re        = 1'b1;
                        read_count_d  = sat_inc(read_count_q);
                    end
                end else begin
                    lat_d = lat_q - 1'b1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q       <= ST_IDLE;
            op_q          <= OP_READ;
            lat_q         <= '0;
            addr_q        <= '0;
            wdat_q        <= '0;
            read_count_q  <= '0;
            write_count_q <= '0;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            lat_q         <= lat_d;
            addr_q        <= addr_d;
            wdat_q        <= wdat_d;
            read_count_q  <= read_count_d;
            write_count_q <= write_count_d;
        end
    end

    block_ram #(
        .IDX_BITS (IDX_BITS),
        .DAT_BITS (BLK_BITS)
    ) u_block_ram (
        .clk_i    (CLK),
        .rst_i    (RESET),
        .we_i     (ram_we),
        .wr_idx_i (ram_idx),
        .wr_dat_i (wdat_q),
        .re_i     (ram_re),
        .rd_idx_i (ram_idx),
        .rd_dat_o (bus.block_read_2DC)
    );

    assign bus.block_read_2DC_valid  = (state_q == ST_RESP) && (op_q == OP_READ);
    assign bus.block_write_2DC_valid = (state_q == ST_RESP) && (op_q == OP_WRITE);
    assign bus.busy                  = (state_q != ST_IDLE);
    assign bus.read_count            = read_count_q;
    assign bus.write_count           = write_count_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder with LATENCY=4, IDX_BITS=6.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_data_mem_responder;

    localparam int LAT = 4;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    data_mem_responder_if bus();

    data_mem_responder #(
        .LATENCY  (LAT),
        .IDX_BITS (6)
    ) dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b, expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_cnt(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_blk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Raise one request line (called just after a falling edge with the DUT idle),
    // wait for its completion pulse, check latency and exclusivity, drop the line,
    // then check the pulse lasted one cycle and the DUT is idle again.
    task automatic run_op(input string tag, input logic is_wr,
                          input logic [31:0] addr, input logic [255:0] wdat);
        int cyc;
        bus.address_fDC     = addr;
        bus.block_write_fDC = wdat;
        if (is_wr) bus.dBlkWrite = 1'b1;
        else       bus.dBlkRead  = 1'b1;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!(is_wr ? bus.block_write_2DC_valid : bus.block_read_2DC_valid) && cyc < 40);
        // Accept edge plus LAT edges: the pulse is seen at the (LAT+1)th falling edge.
        chk_int({tag, "_latency"}, cyc, LAT + 1);
        chk_bit({tag, "_other_valid"},
                is_wr ? bus.block_read_2DC_valid : bus.block_write_2DC_valid, 1'b0);
        if (is_wr) bus.dBlkWrite = 1'b0;
        else       bus.dBlkRead  = 1'b0;
        @(negedge clk);
        chk_bit({tag, "_pulse_end"},
                is_wr ? bus.block_write_2DC_valid : bus.block_read_2DC_valid, 1'b0);
        chk_bit({tag, "_idle_gap"}, bus.busy, 1'b0);
    endtask

    initial begin
        logic [255:0] d_a5;
        logic [255:0] d_1;
        logic [255:0] d_5a;
        logic [255:0] d_2;
        logic [255:0] d_3;
        logic [255:0] d_4;
        logic         seen;

        d_a5 = {32{8'hA5}};
        d_1  = {8{32'h1234_5678}};
        d_5a = {32{8'h5A}};
        d_2  = {8{32'hCAFE_F00D}};
        d_3  = {8{32'hDEAD_BEEF}};
        d_4  = {4{64'h0123_4567_89AB_CDEF}};

        checks = 0;
        errors = 0;
        rst                 = 1'b1;
        bus.address_fDC     = '0;
        bus.dBlkRead        = 1'b0;
        bus.dBlkWrite       = 1'b0;
        bus.block_write_fDC = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk_bit("rst_busy",   bus.busy, 1'b0);
        chk_bit("rst_rvalid", bus.block_read_2DC_valid, 1'b0);
        chk_bit("rst_wvalid", bus.block_write_2DC_valid, 1'b0);
        chk_blk("rst_rdata",  bus.block_read_2DC, 256'd0);
        chk_cnt("rst_rcount", bus.read_count, 16'd0);
        chk_cnt("rst_wcount", bus.write_count, 16'd0);
        rst = 1'b0;
        @(negedge clk);

        // Write then read the same block
        run_op("wr40", 1'b1, 32'h0000_0040, d_a5);
        chk_cnt("wr40_wcount", bus.write_count, 16'd1);
        run_op("rd40", 1'b0, 32'h0000_0040, '0);
        chk_blk("rd40_data",   bus.block_read_2DC, d_a5);
        chk_cnt("rd40_rcount", bus.read_count, 16'd1);
        chk_cnt("rd40_wcount", bus.write_count, 16'd1);

        // Both requests at once: write completes first, read follows with new data
        bus.dBlkRead = 1'b1;
        run_op("both_wr", 1'b1, 32'h0000_0080, d_1);
        chk_blk("both_rdata_hold", bus.block_read_2DC, d_a5);
        run_op("both_rd", 1'b0, 32'h0000_0080, '0);
        chk_blk("both_rd_data", bus.block_read_2DC, d_1);
        chk_cnt("both_wcount",  bus.write_count, 16'd2);
        chk_cnt("both_rcount",  bus.read_count, 16'd2);

        // Write withdrawn two edges into WAIT
        bus.address_fDC     = 32'h0000_0040;
        bus.block_write_fDC = d_5a;
        bus.dBlkWrite       = 1'b1;
        @(negedge clk);
        chk_bit("abort_busy_wait", bus.busy, 1'b1);
        repeat (2) @(negedge clk);
        bus.dBlkWrite = 1'b0;
        @(negedge clk);
        chk_bit("abort_busy_idle", bus.busy, 1'b0);
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (bus.block_write_2DC_valid || bus.block_read_2DC_valid) seen = 1'b1;
        end
        chk_bit("abort_no_valid", seen, 1'b0);
        chk_cnt("abort_wcount", bus.write_count, 16'd2);
        run_op("abort_rd", 1'b0, 32'h0000_0040, '0);
        chk_blk("abort_array_kept", bus.block_read_2DC, d_a5);
        chk_cnt("abort_rcount", bus.read_count, 16'd3);

        // Read abandoned by an address change during WAIT
        bus.address_fDC = 32'h0000_0040;
        bus.dBlkRead    = 1'b1;
        @(negedge clk);
        bus.address_fDC = 32'h0000_00C0;
        @(negedge clk);
        chk_bit("addr_abort_idle", bus.busy, 1'b0);
        bus.dBlkRead = 1'b0;
        @(negedge clk);
        chk_cnt("addr_abort_rcount", bus.read_count, 16'd3);
        chk_blk("addr_abort_rdata",  bus.block_read_2DC, d_a5);

        // Reset in the middle of a write
        run_op("wr100", 1'b1, 32'h0000_0100, d_2);
        bus.address_fDC     = 32'h0000_0100;
        bus.block_write_fDC = d_3;
        bus.dBlkWrite       = 1'b1;
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk_bit("midrst_busy",   bus.busy, 1'b0);
        chk_bit("midrst_wvalid", bus.block_write_2DC_valid, 1'b0);
        chk_bit("midrst_rvalid", bus.block_read_2DC_valid, 1'b0);
        chk_blk("midrst_rdata",  bus.block_read_2DC, 256'd0);
        chk_cnt("midrst_rcount", bus.read_count, 16'd0);
        chk_cnt("midrst_wcount", bus.write_count, 16'd0);
        bus.dBlkWrite = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_op("rd100", 1'b0, 32'h0000_0100, '0);
        chk_blk("rd100_survives", bus.block_read_2DC, d_2);
        chk_cnt("rd100_rcount",   bus.read_count, 16'd1);

        // Aliasing through the ignored upper index bits, with a saturated read counter
        run_op("wr800", 1'b1, 32'h0000_0800, d_4);
        chk_cnt("wr800_wcount", bus.write_count, 16'd1);
        force dut.read_count_q = 16'hFFFF;
        #1;
        release dut.read_count_q;
        run_op("rd000", 1'b0, 32'h0000_0000, '0);
        chk_blk("alias_data",  bus.block_read_2DC, d_4);
        chk_cnt("sat_rcount",  bus.read_count, 16'hFFFF);
        chk_cnt("sat_wcount",  bus.write_count, 16'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter LATENCY, default 4, meaning edges from request accept to response; legal range 1..15.
REQ-002 SHALL have parameter IDX_BITS, default 6, meaning log2 of the number of 256-bit blocks stored.
REQ-003 SHALL have port CLK  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port RESET  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port address_fDC  input  32  block address from data cache; bits [4:0] ignored.
REQ-006 SHALL have port dBlkRead  input  1  block read request, level, held until accepted.
REQ-007 SHALL have port dBlkWrite  input  1  block write request, level, held until accepted.
REQ-008 SHALL have port block_write_fDC  input  256  write data, sampled at accept.
REQ-009 SHALL have port block_read_2DC  output  256  registered read data.
REQ-010 SHALL have port block_read_2DC_valid  output  1  one-cycle read-complete pulse.
REQ-011 SHALL have port block_write_2DC_valid  output  1  one-cycle write-complete pulse.
REQ-012 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-013 SHALL have ports read_count and write_count  output  16 each  saturating completed-operation counters.

Function
REQ-014 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-015 IDLE: on an edge with dBlkRead or dBlkWrite high, SHALL latch the operation, index address_fDC[IDX_BITS+4:5] and block_write_fDC, load the counter with LATENCY-1, and go to WAIT.
REQ-016 Both requests high in IDLE: write SHALL win; the read stays pending and is accepted from IDLE afterwards.
REQ-017 WAIT: SHALL decrement the counter each edge; at counter 0 SHALL go to RESP.
REQ-018 WAIT abort: if the latched request line is low, or address_fDC[31:5] differs from the latched value, at any WAIT edge, SHALL return to IDLE with no memory update, no valid pulse and no count change.
REQ-019 On the edge entering RESP, a write SHALL update the block array; a read SHALL load block_read_2DC from the array.
REQ-020 RESP SHALL last exactly one cycle: the matching valid is high, then the next edge returns to IDLE unconditionally.
REQ-021 Latency: a request accepted at edge k SHALL produce valid high in the cycle after edge k+LATENCY.
REQ-022 The two valid outputs SHALL never be high together; each SHALL be high only in RESP.
REQ-023 A request still high in the RESP cycle SHALL NOT be re-accepted; acceptance occurs only from IDLE, giving a minimum 1-cycle IDLE gap between operations.
REQ-024 block_read_2DC SHALL hold its value until the next completed read.
REQ-025 Counters SHALL increment on RESP entry for their operation type and saturate at 16'hFFFF.
REQ-026 Read-after-write to the same block SHALL return the written data.
REQ-027 Address bits above IDX_BITS+4 SHALL be ignored, so the array aliases by wrap-around.

Reset
REQ-028 RESET high SHALL immediately force IDLE, counter 0, both valids 0, busy 0, block_read_2DC 0, and both counts 0.
REQ-029 RESET mid-WAIT SHALL discard the operation with no array write.
REQ-030 The block array SHALL NOT be reset; its contents survive RESET.

Structure
REQ-031 FSM state encoding and the block-width constant (256) SHALL live in a shared package with the other memory-interface constants.
REQ-032 The block array SHALL be one sub-module, block_ram, with 1 write port and 1 read port, both synchronous.

Verification
REQ-033 LATENCY=4: read accepted at edge 10 -> block_read_2DC_valid high only in the cycle after edge 14, with previously written data.
REQ-034 Write 256'hA5...A5 to 0x0000_0040, then read 0x0000_0040 -> same data, write_count=1 and read_count=1.
REQ-035 dBlkRead and dBlkWrite both high in IDLE -> write pulse first, then read pulse with the new data; no overlap of the valids.
REQ-036 dBlkWrite dropped 2 edges into WAIT -> no valid pulse; array unchanged; write_count unchanged.
REQ-037 RESET asserted mid-WAIT -> outputs 0 immediately; a following read of an earlier-written block still returns its data.
REQ-038 IDX_BITS=6: write 0x0000_0800 then read 0x0000_0000 -> aliased data returned; read_count preloaded to FFFF stays FFFF.
